// File: rtl/shift_seq.sv
// shift_seq: sequential shifter, one 1-bit step per clock.
// Optional feature: define SHIFT_SEQ_CARRY_EN to add the carry output
// (last bit shifted out). The default build leaves it out.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a request, in_ready=1
// S_SHIFT | applying one step per cycle, counter counts down
// S_DONE  | result on C with out_valid=1 until out_ready

`ifndef FUNC_LLS
`define FUNC_LLS 4'd0
`endif
`ifndef FUNC_LRS
`define FUNC_LRS 4'd1
`endif
`ifndef FUNC_ALS
`define FUNC_ALS 4'd2
`endif
`ifndef FUNC_ARS
`define FUNC_ARS 4'd3
`endif

module shift_seq #(
  parameter int data_width = 16,
  parameter int amt_width  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] A,
  input  logic [3:0]            FuncCode,
  input  logic [amt_width-1:0]  amount,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef SHIFT_SEQ_CARRY_EN
  output logic                  carry,
`endif
  output logic [data_width-1:0] C
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [amt_width-1:0] CNT_ONE = amt_width'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic [data_width-1:0] r_work;
  logic [data_width-1:0] w_step;
  logic [3:0]            r_func;
  logic [amt_width-1:0]  r_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One 1-bit step of the latched operation; unknown codes behave as ARS.
  always_comb begin
    w_step = r_work;
    case (r_func)
      `FUNC_LLS, `FUNC_ALS: w_step = {r_work[data_width-2:0], 1'b0};
      `FUNC_LRS:            w_step = {1'b0, r_work[data_width-1:1]};
      default:              w_step = {r_work[data_width-1], r_work[data_width-1:1]};
    endcase
  end

  // Working register, latched opcode and down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work <= '0;
      r_func <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_work <= A;
      r_func <= FuncCode;
      r_cnt  <= amount;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end

  // Result is only presented while the result is valid.
  always_comb begin
    C = (r_state == S_DONE) ? r_work : '0;
  end

`ifdef SHIFT_SEQ_CARRY_EN
  logic r_carry;
  logic w_out_bit;

  // Bit leaving the register on this step: MSB for left, LSB for right.
  always_comb begin
    w_out_bit = ((r_func == `FUNC_LLS) || (r_func == `FUNC_ALS)) ?
                r_work[data_width-1] : r_work[0];
  end

  // Carry cleared on accept so a zero-amount request reports 0.
  always_ff @(posedge clk) begin
    if (reset)                     r_carry <= 1'b0;
    else if (w_accept)             r_carry <= 1'b0;
    else if (r_state == S_SHIFT)   r_carry <= w_out_bit;
  end

  // Carry shown alongside the result only.
  always_comb begin
    carry = (r_state == S_DONE) ? r_carry : 1'b0;
  end
`endif

endmodule
